memoria_programa_cargable: RTL and testbench

//  Parametrised MIPS instruction memory with three modes: fetch, clear and byte-serial load.

---
 rtl/memoria_programa_cargable_pkg.sv | 16 +
 rtl/memoria_programa_cargable_byte_packer.sv | 36 +++
 rtl/memoria_programa_cargable.sv | 114 +++++++++++
 tb/tb_memoria_programa_cargable.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/memoria_programa_cargable_pkg.sv
// memoria_pkg: shared state encoding, default geometry and clogb2 for the loadable program memory
package memoria_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, CLEAR = ST_CLEAR, LOAD = ST_LOAD} state_t;
  localparam int DEF_RAM_WIDTH = 32;
  localparam int DEF_RAM_DEPTH = 2048;
  function automatic int clogb2(input int depth);
    int r;
    int d;
    d = depth;
    for (r = 0; d > 0; r++) d = d >> 1;
    return r;
  endfunction
endpackage

// File: rtl/memoria_programa_cargable_byte_packer.sv
// byte_packer: assembles MSB-first bytes into words
//   i_clk        clock
//   i_clear      synchronous clear of shift register and byte count
//   i_valid      i_byte valid this cycle
//   i_byte       incoming byte
//   o_word       word including the current byte (meaningful with o_word_valid)
//   o_word_valid the current byte completes a word
module byte_packer import memoria_pkg::*; #(
  parameter int RAM_WIDTH      = DEF_RAM_WIDTH,
  parameter int BYTES_PER_WORD = RAM_WIDTH / 8
) (
  input  logic                 i_clk,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [7:0]           i_byte,
  output logic [RAM_WIDTH-1:0] o_word,
  output logic                 o_word_valid
);
  localparam int CNT_W = clogb2(BYTES_PER_WORD);
  logic [RAM_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]     r_bcnt;
  logic                 w_last;
  assign w_last       = r_bcnt == CNT_W'(BYTES_PER_WORD - 1);
  // Combinational so the completing byte is written in the same cycle it arrives
  assign o_word       = (r_shift << 8) | RAM_WIDTH'(i_byte);
  assign o_word_valid = i_valid && w_last;
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_shift <= '0;
      r_bcnt  <= '0;
    end else if (i_valid) begin
      r_shift <= o_word;
      r_bcnt  <= w_last ? '0 : r_bcnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/memoria_programa_cargable.sv
// memoria_programa_cargable: MIPS instruction memory with fetch, full clear and byte-serial load
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_fetch_en, i_addr, o_data     registered fetch read port (serviced only in IDLE)
//   i_clear_req, o_clear_done      start a full zero-fill / one-cycle completion pulse
//   i_load_start, i_load_valid,
//   i_load_byte, i_load_end        byte-serial program load from address 0
//   o_ready                        high in IDLE
//   o_words_loaded                 complete words written by the last load
//   o_load_overflow                sticky, a word arrived with the array full
module memoria_programa_cargable import memoria_pkg::*; #(
  parameter int    RAM_WIDTH       = DEF_RAM_WIDTH,
  parameter int    RAM_DEPTH       = DEF_RAM_DEPTH,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string INIT_FILE       = "",
  localparam int   BYTES_PER_WORD  = RAM_WIDTH / 8,
  localparam int   ADDR_W          = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_fetch_en,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [RAM_WIDTH-1:0] o_data,
  input  logic                 i_clear_req,
  input  logic                 i_load_start,
  input  logic                 i_load_valid,
  input  logic [7:0]           i_load_byte,
  input  logic                 i_load_end,
  output logic                 o_ready,
  output logic                 o_clear_done,
  output logic [ADDR_W:0]      o_words_loaded,
  output logic                 o_load_overflow
);
  localparam int PTR_W = ADDR_W + 1;
  logic [RAM_WIDTH-1:0] r_bram [RAM_DEPTH] = '{default: '0};
  state_t               r_state, w_next;
  logic [ADDR_W-1:0]    r_ctr, w_waddr;
  logic [PTR_W-1:0]     r_ptr, w_ptr_next, r_words_loaded;
  logic                 r_overflow, r_clear_done;
  logic [RAM_WIDTH-1:0] r_ram_data, w_wdata, w_word;
  logic                 w_ctr_last, w_start_load, w_load_end, w_room, w_we;
  logic                 w_word_valid, w_pk_clear, w_pk_valid;
  assign w_ctr_last   = r_ctr == ADDR_W'(RAM_DEPTH - 1);
  // Clear has priority: a simultaneous load request is dropped
  assign w_start_load = r_state == IDLE && !i_clear_req && i_load_start;
  assign w_load_end   = r_state == LOAD && i_load_end;
  assign w_room       = r_ptr < PTR_W'(RAM_DEPTH);
  assign w_pk_valid   = r_state == LOAD && i_load_valid;
  assign w_pk_clear   = i_reset || w_start_load || w_load_end;
  byte_packer #(.RAM_WIDTH(RAM_WIDTH), .BYTES_PER_WORD(BYTES_PER_WORD)) u_packer (
    .i_clk       (i_clk),
    .i_clear     (w_pk_clear),
    .i_valid     (w_pk_valid),
    .i_byte      (i_load_byte),
    .o_word      (w_word),
    .o_word_valid(w_word_valid)
  );
  always_comb begin
    w_next = (r_state == IDLE)  ? (i_clear_req ? CLEAR : (i_load_start ? LOAD : IDLE)) :
             (r_state == CLEAR) ? (w_ctr_last ? IDLE : CLEAR) :
             (r_state == LOAD)  ? (i_load_end ? IDLE : LOAD) : IDLE;
    w_we       = 1'b0;
    w_waddr    = r_ctr;
    w_wdata    = '0;
    w_ptr_next = r_ptr;
    // Reset blocks the write of the cycle it arrives in, so an abort is immediate
    if (r_state == CLEAR) begin
      w_we = !i_reset;
    end else if (r_state == LOAD && w_word_valid && w_room) begin
      w_we       = !i_reset;
      w_waddr    = r_ptr[ADDR_W-1:0];
      w_wdata    = w_word;
      w_ptr_next = r_ptr + PTR_W'(1);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_we) r_bram[w_waddr] <= w_wdata;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_ctr          <= '0;
      r_ptr          <= '0;
      r_words_loaded <= '0;
      r_overflow     <= 1'b0;
      r_clear_done   <= 1'b0;
      r_ram_data     <= '0;
    end else begin
      r_state      <= w_next;
      r_clear_done <= r_state == CLEAR && w_ctr_last;
      if (r_state == IDLE && i_clear_req) r_ctr <= '0;
      else if (r_state == CLEAR) r_ctr <= w_ctr_last ? '0 : r_ctr + ADDR_W'(1);
      r_ptr      <= w_start_load ? '0 : w_ptr_next;
      r_overflow <= w_start_load ? 1'b0 :
                    r_overflow || (r_state == LOAD && w_word_valid && !w_room);
      // w_ptr_next so a word completed on the end cycle is counted
      if (w_load_end) r_words_loaded <= w_ptr_next;
      if (r_state == IDLE && i_fetch_en) r_ram_data <= r_bram[i_addr];
    end
  end
  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low
    assign o_data = r_ram_data;
  end else begin : g_high
    logic [RAM_WIDTH-1:0] r_dout;
    always_ff @(posedge i_clk) begin
      if (i_reset) r_dout <= '0;
      else r_dout <= r_ram_data;
    end
    assign o_data = r_dout;
  end
  assign o_ready         = r_state == IDLE;
  assign o_clear_done    = r_clear_done;
  assign o_words_loaded  = r_words_loaded;
  assign o_load_overflow = r_overflow;
endmodule

// File: tb/tb_memoria_programa_cargable.sv
// tb_memoria_programa_cargable: directed checks of fetch latency, clear, load, overflow and reset abort
module tb_memoria_programa_cargable;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_fetch_en = 0, a_clear_req = 0, a_load_start = 0, a_load_valid = 0, a_load_end = 0;
  logic [3:0]  a_addr = '0;
  logic [7:0]  a_load_byte = '0;
  logic [31:0] a_data;
  logic        a_ready, a_clear_done, a_ovf;
  logic [4:0]  a_words;
  logic        b_fetch_en = 0, b_clear_req = 0, b_load_start = 0, b_load_valid = 0, b_load_end = 0;
  logic [1:0]  b_addr = '0;
  logic [7:0]  b_load_byte = '0;
  logic [31:0] b_data;
  logic        b_ready, b_clear_done, b_ovf;
  logic [2:0]  b_words;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  memoria_programa_cargable #(.RAM_WIDTH(32), .RAM_DEPTH(16), .RAM_PERFORMANCE("HIGH_PERFORMANCE")) dut_a (
    .i_clk(clk), .i_reset(rst), .i_fetch_en(a_fetch_en), .i_addr(a_addr), .o_data(a_data),
    .i_clear_req(a_clear_req), .i_load_start(a_load_start), .i_load_valid(a_load_valid),
    .i_load_byte(a_load_byte), .i_load_end(a_load_end), .o_ready(a_ready),
    .o_clear_done(a_clear_done), .o_words_loaded(a_words), .o_load_overflow(a_ovf));

  memoria_programa_cargable #(.RAM_WIDTH(32), .RAM_DEPTH(4), .RAM_PERFORMANCE("LOW_LATENCY")) dut_b (
    .i_clk(clk), .i_reset(rst), .i_fetch_en(b_fetch_en), .i_addr(b_addr), .o_data(b_data),
    .i_clear_req(b_clear_req), .i_load_start(b_load_start), .i_load_valid(b_load_valid),
    .i_load_byte(b_load_byte), .i_load_end(b_load_end), .o_ready(b_ready),
    .o_clear_done(b_clear_done), .o_words_loaded(b_words), .o_load_overflow(b_ovf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] pat(input int i);
    return {8'(i), 8'h5A, 8'hC3, 8'(8'hF0 ^ i)};
  endfunction

  task automatic send_a(input logic [7:0] b, input logic e);
    a_load_valid = 1; a_load_byte = b; a_load_end = e;
    tick;
    a_load_valid = 0; a_load_end = 0;
  endtask

  task automatic word_a(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_a(w[31-8*k -: 8], 1'b0);
  endtask

  task automatic send_b(input logic [7:0] b);
    b_load_valid = 1; b_load_byte = b;
    tick;
    b_load_valid = 0;
  endtask

  task automatic end_a;
    a_load_end = 1; tick; a_load_end = 0;
  endtask

  task automatic start_a;
    a_load_start = 1; tick; a_load_start = 0;
  endtask

  task automatic fetch_a(input int addr, input logic [31:0] exp, input string tag);
    a_fetch_en = 1; a_addr = 4'(addr);
    tick;
    a_fetch_en = 0;
    tick;
    chk(tag, a_data, exp);
  endtask

  task automatic fetch_b(input int addr, input logic [31:0] exp, input string tag);
    b_fetch_en = 1; b_addr = 2'(addr);
    tick;
    b_fetch_en = 0;
    chk(tag, b_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] prog [8];
    int low, dones, done_at;
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    tick; tick;
    chk("rst_data", a_data, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_done", a_clear_done, 0);
    chk("rst_words", a_words, 0);
    chk("rst_ovf", a_ovf, 0);
    rst = 0;
    start_a;
    chk("load_busy", a_ready, 0);
    for (int i = 0; i < 8; i++) send_a(prog[i], 1'b0);
    end_a;
    chk("load_words2", a_words, 2);
    chk("load_ready", a_ready, 1);
    a_fetch_en = 1; a_addr = 0;
    tick;
    a_fetch_en = 0;
    chk("hp_lat1", a_data, 0);
    tick;
    chk("hp_lat2_w0", a_data, 32'h20080005);
    fetch_a(1, 32'h20090007, "w1");
    start_a;
    send_a(8'hAA, 0); send_a(8'hBB, 0); send_a(8'hCC, 0);
    end_a;
    chk("partial_words", a_words, 0);
    fetch_a(0, 32'h20080005, "partial_nowrite");
    start_a;
    send_a(8'h11, 0); send_a(8'h22, 0); send_a(8'h33, 0); send_a(8'h44, 1);
    chk("byte_with_end_words", a_words, 1);
    fetch_a(0, 32'h11223344, "repack_w0");
    start_a;
    for (int i = 0; i < 16; i++) word_a(pat(i));
    end_a;
    chk("full_words", a_words, 16);
    chk("full_no_ovf", a_ovf, 0);
    fetch_a(15, pat(15), "full_w15");
    a_clear_req = 1; a_load_start = 1;
    tick;
    a_clear_req = 0; a_load_start = 0;
    low = 0; dones = 0; done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (!a_ready) low++;
      if (a_clear_done) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
      tick;
    end
    chk("clr_busy_cycles", low, 16);
    chk("clr_done_pulses", dones, 1);
    chk("clr_done_cycle", done_at, 16);
    for (int i = 0; i < 16; i++) fetch_a(i, 0, $sformatf("clr_zero_%0d", i));
    start_a;
    for (int i = 0; i < 16; i++) word_a(pat(i));
    end_a;
    a_clear_req = 1; tick; a_clear_req = 0;
    for (int k = 0; k < 7; k++) tick;
    rst = 1;
    tick;
    chk("abort_ready", a_ready, 1);
    chk("abort_done", a_clear_done, 0);
    rst = 0;
    tick;
    chk("abort_done_after", a_clear_done, 0);
    chk("abort_words", a_words, 0);
    fetch_a(6, 0, "abort_w6_cleared");
    fetch_a(7, pat(7), "abort_w7_kept");
    fetch_a(8, pat(8), "abort_w8_kept");
    fetch_a(15, pat(15), "abort_w15_kept");
    b_load_start = 1; tick; b_load_start = 0;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++) send_b(pat(32 + i) >> (24 - 8 * k));
    b_load_end = 1; tick; b_load_end = 0;
    chk("ovf_words", b_words, 4);
    chk("ovf_flag", b_ovf, 1);
    chk("ovf_ready", b_ready, 1);
    for (int i = 0; i < 4; i++) fetch_b(i, pat(32 + i), $sformatf("ovf_w%0d", i));
    b_load_start = 1; tick; b_load_start = 0;
    chk("ovf_cleared", b_ovf, 0);
    b_load_end = 1; tick; b_load_end = 0;
    chk("empty_words", b_words, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
